branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch direction predictor for the RV32 core.
- Lookup side: returns a taken/not-taken prediction for the fetch PC.
- Update side: consumes the resolved branch outcome produced by the branch-decision logic (taken, from zero/negative flags and funct3).
- Tagged, direct-mapped table of 2-bit saturating counters, plus branch and mispredict statistics counters.

Parameters:
- ENTRIES, 16: number of table entries; power of 2, minimum 2.
- IDX_W, $clog2(ENTRIES): index width; derived, do not override.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk_i  input  1  core clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- pc_i  input  32  fetch PC to predict.
- predict_taken_o  output  1  prediction for pc_i; combinational.
- predict_hit_o  output  1  pc_i matched a valid entry; combinational.
- update_valid_i  input  1  a conditional branch resolved this cycle.
- update_pc_i  input  32  PC of the resolved branch.
- update_taken_i  input  1  resolved outcome.
- update_predicted_i  input  1  prediction that was used for this branch.
- clear_i  input  1  synchronous flush of all table entries.
- branch_count_o  output  CNT_W  resolved branches since reset.
- mispredict_count_o  output  CNT_W  mispredictions since reset.

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. PC bits [1:0] are ignored.
- Each entry holds: valid (1 bit), tag, and a 2-bit counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
- Reset (rst_ni low, asynchronous): all valid bits cleared, all counters set to 01, both statistics counters set to 0.
  - Outputs during reset: predict_hit_o = 0, predict_taken_o = 0.
- Lookup is purely combinational:
  - predict_hit_o = valid[idx] && tag match.
  - predict_taken_o = predict_hit_o && counter[1].
  - A miss always predicts not-taken.
- Update, on a clock edge with update_valid_i = 1:
  - Hit on update_pc_i: counter increments if taken, decrements if not. It saturates at 11 and 00; there is no wrap.
  - Miss (invalid entry or tag mismatch): the entry is allocated (overwriting any aliasing entry). valid = 1, tag written, counter = 10 if taken, else 01.
  - branch_count_o increments by 1.
  - mispredict_count_o increments by 1 when update_taken_i != update_predicted_i.
  - Both statistics counters wrap modulo 2^CNT_W.
- update_valid_i = 0: update_pc_i, update_taken_i and update_predicted_i are ignored and no state changes.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update state (no bypass). The new state is visible the next cycle.
- clear_i = 1 on an edge:
  - All valid bits cleared and all counters set to 01.
  - Statistics counters are not affected.
  - If update_valid_i is also 1 that cycle, clear wins for the table and the update is dropped. The statistics counters still count the update.
- Reset asserted mid-operation: state returns to reset values immediately, independent of the clock.

Test Plan:
- Reset, then pc_i = 0x0000_0100 → predict_hit_o = 0, predict_taken_o = 0, both counters = 0.
- Update pc 0x100 taken with predicted 0, then lookup pc_i = 0x100 → hit = 1, taken = 1; branch_count = 1, mispredict_count = 1.
- Update pc 0x100: four not-taken (counter saturates at 00), then one taken → counter 01, prediction 0. Follow with taken updates → 10, then 11; a further taken update stays at 11.
- Aliasing with ENTRIES = 16: allocate 0x100, then update 0x500 (same index, different tag) not-taken → lookup 0x100 misses; lookup 0x500 hits, taken = 0.
- Same-cycle lookup and update of 0x100 (counter 01 → 10): predict_taken_o = 0 in that cycle and 1 in the next.
- clear_i with a concurrent update → all lookups miss afterwards; branch_count still increments. Asserting rst_ni low between clock edges zeroes the counters immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// Tagged, direct-mapped branch direction predictor built from 2-bit saturating counters.
// It also keeps running counts of resolved branches and mispredictions.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      pc_i,
    output logic             predict_taken_o,
    output logic             predict_hit_o,
    input  logic             update_valid_i,
    input  logic [31:0]      update_pc_i,
    input  logic             update_taken_i,
    input  logic             update_predicted_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] branch_count_o,
    output logic [CNT_W-1:0] mispredict_count_o
);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [CNT_W-1:0] branch_count_q;
    logic [CNT_W-1:0] mispredict_count_q;

    // The byte-offset bits of both PCs never select anything.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_i[1:0], update_pc_i[1:0]};

    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    endfunction

    assign lk_idx = pc_i[IDX_W+1:2];
    assign lk_tag = pc_i[31:IDX_W+2];
    assign up_idx = update_pc_i[IDX_W+1:2];
    assign up_tag = update_pc_i[31:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Lookup reads the registered table only, so a same-cycle update shows up one cycle later.
    assign predict_hit_o   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign predict_taken_o = predict_hit_o && ctr_q[lk_idx][1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (clear_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (update_valid_i) begin
            valid_q[up_idx] <= 1'b1;
            // A miss allocates at the weak state that matches the observed outcome.
            ctr_q[up_idx]   <= up_hit ? sat_step(ctr_q[up_idx], update_taken_i)
                                      : {update_taken_i, ~update_taken_i};
        end
    end

    // Tags are qualified by the valid bits and need no reset.
    always_ff @(posedge clk_i) begin
        if (update_valid_i && !clear_i) begin
            tag_q[up_idx] <= up_tag;
        end
    end

    // The statistics still count an update that a concurrent clear drops from the table.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (update_valid_i) begin
            branch_count_q <= branch_count_q + CNT_W'(1);
            if (update_taken_i != update_predicted_i) begin
                mispredict_count_q <= mispredict_count_q + CNT_W'(1);
            end
        end
    end

    assign branch_count_o     = branch_count_q;
    assign mispredict_count_o = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed vector table, clear/reset sequences,
// and random traffic compared against a behavioural table model.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        predict_taken;
    logic        predict_hit;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic        update_predicted;
    logic        clear;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int n_pass = 0;
    int n_total = 0;

    branch_predictor #(.ENTRIES(16), .CNT_W(32)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .pc_i               (pc),
        .predict_taken_o    (predict_taken),
        .predict_hit_o      (predict_hit),
        .update_valid_i     (update_valid),
        .update_pc_i        (update_pc),
        .update_taken_i     (update_taken),
        .update_predicted_i (update_predicted),
        .clear_i            (clear),
        .branch_count_o     (branch_count),
        .mispredict_count_o (mispredict_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: per-slot valid/tag and a direction strength 0..3.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    int          m_str   [16];
    int unsigned m_br;
    int unsigned m_mis;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_str[i]   = 1;
        end
        m_br  = 0;
        m_mis = 0;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int unsigned slot = (a / 4) % 16;
        return m_valid[slot] && (m_tag[slot] == a / 64);
    endfunction

    function automatic bit model_taken(input logic [31:0] a);
        return model_hit(a) && (m_str[(a / 4) % 16] >= 2);
    endfunction

    function automatic void model_edge();
        int unsigned slot;
        if (update_valid) begin
            m_br++;
            if (update_taken != update_predicted) m_mis++;
        end
        if (clear) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0;
                m_str[i]   = 1;
            end
        end else if (update_valid) begin
            slot = (update_pc / 4) % 16;
            if (model_hit(update_pc)) begin
                if (update_taken) m_str[slot] = (m_str[slot] < 3) ? m_str[slot] + 1 : 3;
                else              m_str[slot] = (m_str[slot] > 0) ? m_str[slot] - 1 : 0;
            end else begin
                m_valid[slot] = 1'b1;
                m_tag[slot]   = update_pc / 64;
                m_str[slot]   = update_taken ? 2 : 1;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic [31:0] p, input logic uv, input logic [31:0] upc,
                          input logic ut, input logic up, input logic clr);
        pc = p; update_valid = uv; update_pc = upc;
        update_taken = ut; update_predicted = up; clear = clr;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic        up;
        logic        eh;
        logic        et;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic [31:0] p, input logic uv, input logic [31:0] upc,
                                input logic ut, input logic up, input logic eh, input logic et);
        vec_t v;
        v.pc = p; v.uv = uv; v.upc = upc; v.ut = ut; v.up = up; v.eh = eh; v.et = et;
        return v;
    endfunction

    initial begin
        // Expected hit/taken are the pre-update lookup of that same cycle.
        vecs[0]  = mk(32'h100, 0, 32'h0,   0, 0, 0, 0);
        vecs[1]  = mk(32'h100, 1, 32'h100, 1, 0, 0, 0);
        vecs[2]  = mk(32'h100, 0, 32'h0,   0, 0, 1, 1);
        vecs[3]  = mk(32'h100, 1, 32'h100, 0, 1, 1, 1);
        vecs[4]  = mk(32'h100, 1, 32'h100, 0, 0, 1, 0);
        vecs[5]  = mk(32'h100, 1, 32'h100, 0, 0, 1, 0);
        vecs[6]  = mk(32'h100, 1, 32'h100, 0, 0, 1, 0);
        vecs[7]  = mk(32'h100, 1, 32'h100, 1, 0, 1, 0);
        vecs[8]  = mk(32'h100, 1, 32'h100, 1, 0, 1, 0);
        vecs[9]  = mk(32'h100, 1, 32'h100, 1, 1, 1, 1);
        vecs[10] = mk(32'h100, 1, 32'h100, 1, 1, 1, 1);
        vecs[11] = mk(32'h100, 0, 32'h0,   0, 0, 1, 1);
        vecs[12] = mk(32'h100, 1, 32'h500, 0, 1, 1, 1);
        vecs[13] = mk(32'h100, 0, 32'h0,   0, 0, 0, 0);
        vecs[14] = mk(32'h500, 0, 32'h0,   0, 0, 1, 0);

        model_reset();
        rst_n = 1'b0;
        set_in(32'h100, 0, 0, 0, 0, 0);
        #12;
        chk("reset_hit", {31'd0, predict_hit}, 0);
        chk("reset_taken", {31'd0, predict_taken}, 0);
        chk("reset_branch_count", branch_count, 0);
        chk("reset_mispredict_count", mispredict_count, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            set_in(vecs[i].pc, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].up, 1'b0);
            #1;
            chk($sformatf("vec%0d_hit", i), {31'd0, predict_hit}, {31'd0, vecs[i].eh});
            chk($sformatf("vec%0d_taken", i), {31'd0, predict_taken}, {31'd0, vecs[i].et});
            tick();
        end
        chk("table_branch_count", branch_count, 10);
        chk("table_mispredict_count", mispredict_count, 5);

        // Clear racing an update: table empties, statistics still count it.
        set_in(32'h0, 1, 32'h104, 1, 0, 0);
        tick();
        set_in(32'h104, 1, 32'h108, 1, 1, 1);
        #1;
        chk("pre_clear_hit", {31'd0, predict_hit}, 1);
        tick();
        set_in(32'h0, 0, 0, 0, 0, 0);
        foreach (vecs[j]) begin end
        pc = 32'h500; #1; chk("clear_miss_500", {31'd0, predict_hit}, 0);
        pc = 32'h104; #1; chk("clear_miss_104", {31'd0, predict_hit}, 0);
        pc = 32'h108; #1; chk("clear_miss_108", {31'd0, predict_hit}, 0);
        pc = 32'h100; #1; chk("clear_miss_100", {31'd0, predict_hit}, 0);
        chk("clear_branch_count", branch_count, 12);
        chk("clear_mispredict_count", mispredict_count, 6);
        tick();

        // Random traffic over a small tag space so hits, aliasing and saturation all occur.
        for (int c = 0; c < 500; c++) begin
            logic [31:0] rp, ru;
            rp = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            ru = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            set_in(rp, 1'($urandom_range(0, 3) != 0), ru, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
            #1;
            chk("rand_hit", {31'd0, predict_hit}, {31'd0, model_hit(rp)});
            chk("rand_taken", {31'd0, predict_taken}, {31'd0, model_taken(rp)});
            chk("rand_branch_count", branch_count, m_br);
            chk("rand_mispredict_count", mispredict_count, m_mis);
            tick();
        end

        // Asynchronous reset between edges, with a known-allocated PC on the lookup port.
        set_in(32'h2c0, 1, 32'h2c0, 1, 0, 0);
        tick();
        set_in(32'h2c0, 0, 0, 0, 0, 0);
        #1;
        chk("pre_async_hit", {31'd0, predict_hit}, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_branch_count", branch_count, 0);
        chk("async_mispredict_count", mispredict_count, 0);
        chk("async_hit", {31'd0, predict_hit}, 0);
        rst_n = 1'b1;
        set_in(32'h2c0, 1, 32'h2c0, 0, 1, 0);
        tick();
        set_in(32'h2c0, 0, 0, 0, 0, 0);
        #1;
        chk("post_reset_branch_count", branch_count, 1);
        chk("post_reset_mispredict_count", mispredict_count, 1);
        chk("post_reset_hit", {31'd0, predict_hit}, 1);
        chk("post_reset_taken", {31'd0, predict_taken}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end
endmodule
